// File: rtl/display_rx.sv
// display_rx: oversampling receiver for the display link; recovers a WIDTH-bit BCD
// word framed by shift-clock and latch edges, all handled in the clk domain.
`default_nettype none

module display_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_in,
  input  logic                          shift_clk_in,
  input  logic                          latch_in,
  output logic [WIDTH-1:0]              bcd_out,
  output logic                          valid,
  output logic                          frame_err,
  output logic                          bcd_err,
  output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] C_OVER = CW'(WIDTH + 1);
  localparam logic [IW-1:0] C_TIMEOUT = IW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] shift_sync;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   shift_hist;
  logic                   latch_hist;
  logic [WIDTH-1:0]       shreg;
  logic [IW-1:0]          idle_cnt;

  logic                   shift_edge;
  logic                   latch_edge;
  logic [WIDTH-1:0]       shreg_next;
  logic [CW-1:0]          cnt_next;
  logic                   nib_err;

  assign shift_edge = shift_sync[SYNC_STAGES-1] & ~shift_hist;
  assign latch_edge = latch_sync[SYNC_STAGES-1] & ~latch_hist;

  // Shift is resolved first so a coincident latch sees the updated word and count.
  always_comb begin
    shreg_next = shreg;
    cnt_next   = bit_cnt;
    if (shift_edge) begin
      shreg_next = {shreg[WIDTH-2:0], data_sync[SYNC_STAGES-1]};
      if (bit_cnt != C_OVER) begin
        cnt_next = bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nib_err = 1'b0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      if (shreg_next[4*i +: 4] > 4'd9) begin
        nib_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sync  <= '0;
      shift_sync <= '0;
      latch_sync <= '0;
      shift_hist <= 1'b0;
      latch_hist <= 1'b0;
    end else begin
      data_sync  <= {data_sync[SYNC_STAGES-2:0], data_in};
      shift_sync <= {shift_sync[SYNC_STAGES-2:0], shift_clk_in};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      shift_hist <= shift_sync[SYNC_STAGES-1];
      latch_hist <= latch_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      bcd_out   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      shreg     <= shreg_next;
      if (latch_edge) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
        if (cnt_next == C_FULL) begin
          bcd_out <= shreg_next;
          valid   <= 1'b1;
          bcd_err <= nib_err;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (shift_edge) begin
        bit_cnt  <= cnt_next;
        idle_cnt <= '0;
      end else if (bit_cnt != '0) begin
        // A stalled partial frame is dropped silently once the link goes quiet.
        if (idle_cnt + 1'b1 == C_TIMEOUT) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_rx.sv
// tb_display_rx: directed self-checking bench for display_rx.
`default_nettype none

module tb_display_rx;

  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in = 1'b0;
  logic        shift_clk_in = 1'b0;
  logic        latch_in = 1'b0;
  logic [15:0] bcd_out;
  logic        valid;
  logic        frame_err;
  logic        bcd_err;
  logic [4:0]  bit_cnt;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic [15:0] last_bcd = '0;
  int v0, f0;

  display_rx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_clk_in(shift_clk_in),
    .latch_in(latch_in), .bcd_out(bcd_out), .valid(valid), .frame_err(frame_err),
    .bcd_err(bcd_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      last_bcd = bcd_out;
    end
    if (frame_err) fe_cnt++;
    if (valid && frame_err) both_cnt++;
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
    shift_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    shift_clk_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_latch();
    @(negedge clk);
    latch_in = 1'b1;
    repeat (4) @(negedge clk);
    latch_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    f0 = fe_cnt;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (bcd_err !== 1'b0) begin errors++; $display("FAIL reset_bcd_err: got %b expected 0", bcd_err); end
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word(input logic [15:0] w, input logic exp_err, input string nm);
    snap();
    shift_word({16'h0, w}, 16);
    do_latch();
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL %s_valid_pulses: got %0d expected 1", nm, valid_cnt - v0); end
    checks++; if (bcd_out !== w) begin errors++; $display("FAIL %s_bcd_out: got %h expected %h", nm, bcd_out, w); end
    checks++; if (last_bcd !== w) begin errors++; $display("FAIL %s_bcd_at_valid: got %h expected %h", nm, last_bcd, w); end
    checks++; if (bcd_err !== exp_err) begin errors++; $display("FAIL %s_bcd_err: got %b expected %b", nm, bcd_err, exp_err); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL %s_frame_err: got %0d expected 0", nm, fe_cnt - f0); end
  endtask

  task automatic test_bad_count(input int n, input logic [15:0] hold, input string nm);
    snap();
    shift_word(32'h0001_5A5A, n);
    checks++; if (bit_cnt !== 5'(n)) begin errors++; $display("FAIL %s_bit_cnt_pre: got %0d expected %0d", nm, bit_cnt, n); end
    do_latch();
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL %s_frame_err: got %0d expected 1", nm, fe_cnt - f0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL %s_valid: got %0d expected 0", nm, valid_cnt - v0); end
    checks++; if (bcd_out !== hold) begin errors++; $display("FAIL %s_bcd_hold: got %h expected %h", nm, bcd_out, hold); end
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL %s_bit_cnt_post: got %0d expected 0", nm, bit_cnt); end
  endtask

  task automatic test_timeout();
    snap();
    shift_word(32'h0000_00A5, 8);
    checks++; if (bit_cnt !== 5'd8) begin errors++; $display("FAIL timeout_bit_cnt_pre: got %0d expected 8", bit_cnt); end
    repeat (TIMEOUT + 5) @(negedge clk);
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL timeout_bit_cnt: got %0d expected 0", bit_cnt); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL timeout_frame_err: got %0d expected 0", fe_cnt - f0); end
    test_word(16'h5678, 1'b0, "after_timeout");
  endtask

  task automatic test_simultaneous();
    logic [15:0] w;
    w = 16'h9999;
    snap();
    shift_word({17'h0, w[15:1]}, 15);
    @(negedge clk);
    data_in = w[0];
    shift_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    shift_clk_in = 1'b1;
    latch_in = 1'b1;
    repeat (4) @(negedge clk);
    latch_in = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL simul_valid: got %0d expected 1", valid_cnt - v0); end
    checks++; if (bcd_out !== 16'h9999) begin errors++; $display("FAIL simul_bcd_out: got %h expected 9999", bcd_out); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL simul_frame_err: got %0d expected 0", fe_cnt - f0); end
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL simul_bit_cnt: got %0d expected 0", bit_cnt); end
  endtask

  task automatic test_async_reset();
    shift_word(32'h0000_0155, 10);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL areset_bcd: got %h expected 0000", bcd_out); end
    checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL areset_bit_cnt: got %0d expected 0", bit_cnt); end
    checks++; if ({valid, frame_err, bcd_err} !== 3'b000) begin errors++; $display("FAIL areset_flags: got %b expected 000", {valid, frame_err, bcd_err}); end
    @(negedge clk);
    shift_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_word(16'h4321, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_word(16'h1234, 1'b0, "w1234");
    test_bad_count(15, 16'h1234, "short15");
    test_bad_count(17, 16'h1234, "long17");
    test_word(16'h12A4, 1'b1, "w12a4");
    test_word(16'h0009, 1'b0, "w0009");
    test_timeout();
    test_simultaneous();
    test_async_reset();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_frame_err_together: got %0d expected 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
